// File: rtl/bit_serializer.sv
// bit_serializer: parallel word to serial bit stream over a valid/ready handshake.
// Optional build macro: SERIALIZER_LSB_FIRST_EN (emit bit 0 first, shift right).
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_valid, hold_valid_nxt;
    logic [WIDTH-1:0] shifter, shifter_nxt;
    logic [CW-1:0]    count, count_nxt;

    logic             at_end;
    logic             head;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    assign at_end    = (count == LAST_CNT);
    assign din_ready = !hold_valid && !reset;
    assign accept    = din_valid && din_ready;

`ifdef SERIALIZER_LSB_FIRST_EN
    assign head    = shifter[0];
    assign shifted = {1'b0, shifter[WIDTH-1:1]};
`else
    assign head    = shifter[WIDTH-1];
    assign shifted = {shifter[WIDTH-2:0], 1'b0};
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shifter    <= '0;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            shifter    <= shifter_nxt;
            count      <= count_nxt;
        end
    end

    // Next-state, hold/shifter movement and serial outputs.
    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        shifter_nxt    = shifter;
        count_nxt      = count;
        out            = 1'b0;
        out_valid      = 1'b0;
        last           = 1'b0;

        // Acceptance only happens with hold empty, so it never
        // collides with a hold-to-shifter load below.
        if (accept) begin
            hold_nxt       = din;
            hold_valid_nxt = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (hold_valid) begin
                    shifter_nxt    = hold;
                    hold_valid_nxt = 1'b0;
                    count_nxt      = '0;
                    state_nxt      = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                out       = head;
                last      = at_end;
                if (at_end) begin
                    count_nxt = '0;
                    if (hold_valid) begin
                        // Gapless handoff to the next word.
                        shifter_nxt    = hold;
                        hold_valid_nxt = 1'b0;
                    end else begin
                        shifter_nxt = shifted;
                        state_nxt   = IDLE;
                    end
                end else begin
                    shifter_nxt = shifted;
                    count_nxt   = count + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: table vectors, hand sequences and randomized stream
// checked against a schedule-based reference model.
module tb_bit_serializer;

    localparam int W = 8;
    localparam int W6 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         out;
    logic         out_valid;
    logic         last;

    logic [W6-1:0] din6;
    logic          din_valid6;
    logic          din_ready6;
    logic          out6;
    logic          out_valid6;
    logic          last6;

    bit_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .out       (out),
        .out_valid (out_valid),
        .last      (last)
    );

    bit_serializer #(.WIDTH(W6)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .din       (din6),
        .din_valid (din_valid6),
        .din_ready (din_ready6),
        .out       (out6),
        .out_valid (out_valid6),
        .last      (last6)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference model: each accepted word gets a start edge. It starts
    // one edge after acceptance, or right after the previous word ends.
    // Hold is free again once its word has started.
    typedef struct {
        int           start;
        logic [W-1:0] word;
    } slot_t;

    slot_t sched[$];
    int    last_start = -100;
    int    last_end   = -100;
    int    vcount = 0;
    int    lcount = 0;

    function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
        return w[i];
`else
        return w[W-1-i];
`endif
    endfunction

    task automatic model_reset();
        sched.delete();
        last_start = -100;
        last_end   = -100;
    endtask

    task automatic run_cycle(input logic v, input logic [W-1:0] d,
                             output logic took);
        int    e;
        int    idx;
        logic  rdy_exp;
        slot_t s;
        e       = cyc + 1;
        rdy_exp = (last_start < e);
        din       = d;
        din_valid = v;
        #1;
        check("din_ready", din_ready, rdy_exp);
        took = v && rdy_exp;
        if (took) begin
            s.start    = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
            s.word     = d;
            last_start = s.start;
            last_end   = s.start + W - 1;
            sched.push_back(s);
        end
        step();
        while (sched.size() > 0 && sched[0].start + W - 1 < cyc)
            void'(sched.pop_front());
        if (out_valid) vcount++;
        if (last) lcount++;
        if (sched.size() > 0 && sched[0].start <= cyc) begin
            idx = cyc - sched[0].start;
            check("out_valid", out_valid, 1);
            check("out", out, exp_bit(sched[0].word, idx));
            check("last", last, (idx == W - 1));
        end else begin
            check("out_valid_idle", out_valid, 0);
            check("out_idle", out, 0);
            check("last_idle", last, 0);
        end
    endtask

    logic [W-1:0] src_q[$];

    task automatic send_all(input int tail, output int stalls);
        logic took;
        int   guard;
        stalls = 0;
        guard  = 0;
        while (src_q.size() > 0 && guard < 200) begin
            run_cycle(1'b1, src_q[0], took);
            if (took) void'(src_q.pop_front());
            else stalls++;
            guard++;
        end
        check("send_bound", src_q.size(), 0);
        src_q.delete();
        din_valid = 1'b0;
        repeat (tail) run_cycle(1'b0, '0, took);
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] msb;
        logic [7:0] lsb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic         took;
        logic         pres;
        logic [W-1:0] pw;
        logic [7:0]   expv;
        int           stalls;
        logic         ref6[$];
        logic [W6-1:0] wq6[$];
        logic [W6-1:0] w6;
        int           got, first, acc_edge, gaps;
        logic         tk;

        tbl[0] = '{8'h2B, 8'b0010_1011, 8'b1101_0100};
        tbl[1] = '{8'hA5, 8'b1010_0101, 8'b1010_0101};
        tbl[2] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};
        tbl[3] = '{8'h81, 8'b1000_0001, 8'b1000_0001};
        tbl[4] = '{8'h0F, 8'b0000_1111, 8'b1111_0000};
        tbl[5] = '{8'hF0, 8'b1111_0000, 8'b0000_1111};

        reset = 1'b1;
        din = '0;
        din_valid = 1'b0;
        din6 = '0;
        din_valid6 = 1'b0;
        step();
        step();
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_last", last, 0);
        check("rst_ready", din_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", din_ready, 1);

        // Table-driven single words.
        for (int i = 0; i < 6; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            expv = tbl[i].lsb;
`else
            expv = tbl[i].msb;
`endif
            din = tbl[i].word;
            din_valid = 1'b1;
            #1;
            check("tbl_ready", din_ready, 1);
            step();
            din_valid = 1'b0;
            check("tbl_first_idle", out_valid, 0);
            check("tbl_ready_low", din_ready, 0);
            for (int b = 0; b < 8; b++) begin
                step();
                check("tbl_out", out, expv[7-b]);
                check("tbl_valid", out_valid, 1);
                check("tbl_last", last, (b == 7));
            end
            step();
            check("tbl_end_valid", out_valid, 0);
            check("tbl_end_out", out, 0);
            check("tbl_end_ready", din_ready, 1);
        end

        // Back-to-back: 16 contiguous bits, two last pulses.
        vcount = 0;
        lcount = 0;
        src_q = '{8'hA5, 8'h3C};
        send_all(14, stalls);
        check("b2b_bits", vcount, 16);
        check("b2b_lasts", lcount, 2);

        // Backpressure: third word waits for hold to drain.
        vcount = 0;
        lcount = 0;
        src_q = '{8'hA5, 8'h3C, 8'hE7};
        send_all(20, stalls);
        check("bp_stalled", (stalls > 0), 1);
        check("bp_bits", vcount, 24);
        check("bp_lasts", lcount, 3);

        // Reset mid-word with a word waiting in hold.
        run_cycle(1'b1, 8'hFF, took);
        run_cycle(1'b1, 8'h0F, took);
        run_cycle(1'b1, 8'h0F, took);
        check("rm_hold_taken", took, 1);
        din_valid = 1'b0;
        run_cycle(1'b0, '0, took);
        reset = 1'b1;
        #1;
        check("rm_ready_in_rst", din_ready, 0);
        step();
        check("rm_out", out, 0);
        check("rm_valid", out_valid, 0);
        check("rm_last", last, 0);
        reset = 1'b0;
        model_reset();
        #1;
        check("rm_ready_after", din_ready, 1);
        vcount = 0;
        src_q = '{8'h81};
        send_all(12, stalls);
        check("rm_bits", vcount, 8);

        // Randomized stream with random source gaps.
        vcount = 0;
        pres = 1'b0;
        pw = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pres && ($urandom % 4) != 0) begin
                pres = 1'b1;
                pw = W'($urandom);
            end
            run_cycle(pres, pw, took);
            if (took) pres = 1'b0;
        end
        din_valid = 1'b0;
        repeat (20) run_cycle(1'b0, '0, took);

        // WIDTH=6 stream against a bit-by-bit reference.
        wq6 = '{6'b001010, 6'b110101};
        foreach (wq6[k]) begin
            w6 = wq6[k];
            for (int i = 0; i < W6; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
                ref6.push_back(w6[i]);
`else
                ref6.push_back(w6[W6-1-i]);
`endif
            end
        end
        got = 0;
        first = -1;
        acc_edge = -1;
        gaps = 0;
        for (int c = 0; c < 40; c++) begin
            if (wq6.size() > 0) begin
                din6 = wq6[0];
                din_valid6 = 1'b1;
            end else begin
                din_valid6 = 1'b0;
            end
            #1;
            tk = din_valid6 && din_ready6;
            if (tk && acc_edge < 0) acc_edge = cyc + 1;
            step();
            if (tk) void'(wq6.pop_front());
            if (out_valid6) begin
                if (first < 0) first = cyc;
                if (got < 12) begin
                    check("w6_out", out6, ref6[got]);
                    check("w6_last", last6, (got % 6 == 5));
                end
                got++;
            end else if (first >= 0 && got < 12) begin
                gaps++;
            end
        end
        check("w6_count", got, 12);
        check("w6_gaps", gaps, 0);
        check("w6_latency", first, acc_edge + 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
